// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client round-robin front end that sequences one shared 16-bit ALU operation at a time
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b0,
  input  logic [15:0] req_b1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic lastGrant, grant, accept, idReg;
  logic [2:0] opReg;
  logic [15:0] aReg, bReg, diff;
  logic [31:0] result;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  // A lone requester wins; a tie goes to the one not granted last. Nothing is offered while in reset.
  always_comb begin
    grant = (req_valid == 2'b11) ? ~lastGrant : req_valid[1];
    accept = rst_n && state == IDLE && |req_valid;
    req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  end
  // ALU on the latched operands; SUB is sign-extended, MUL is a full unsigned product
  always_comb begin
    diff = aReg - bReg;
    case (opReg)
      3'd0:    result = {15'd0, {1'b0, aReg} + {1'b0, bReg}};
      3'd1:    result = {{16{diff[15]}}, diff};
      3'd2:    result = {16'd0, aReg & bReg};
      3'd3:    result = {16'd0, aReg | bReg};
      3'd4:    result = {16'd0, aReg ^ bReg};
      3'd5:    result = {16'd0, ~(aReg | bReg)};
      3'd6:    result = {16'd0, ~aReg};
      default: result = {16'd0, aReg} * {16'd0, bReg};
    endcase
  end
  // Sequencer: latch the winner in IDLE, compute in EXEC, hold the response until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      idReg     <= 1'b0;
      opReg     <= 3'd0;
      aReg      <= 16'd0;
      bReg      <= 16'd0;
      rsp_id    <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= EXEC;
          lastGrant <= grant;
          idReg     <= grant;
          opReg     <= grant ? req_op1 : req_op0;
          aReg      <= grant ? req_a1 : req_a0;
          bReg      <= grant ? req_b1 : req_b0;
        end
        EXEC: begin
          state    <= RESP;
          rsp_data <= result;
          rsp_id   <= idReg;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
